ccl_label_scan: RTL

CCL_LABEL_SCAN -- requirements
Module: ccl_label_scan

---
 rtl/ccl_label_scan.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ccl_label_scan.sv
// First-pass raster connected-component labeller: provisional labels plus union-find requests.
// Build option: define CCL_CONN8_EN for 8-connectivity (default is 4-connectivity).
module ccl_label_scan #(
    parameter int unsigned IMG_W   = 64,
    parameter int unsigned LABEL_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pix_valid,
    input  logic               pix_bin,
    input  logic               pix_sof,
    output logic               pix_ready,
    output logic               lbl_valid,
    output logic [LABEL_W-1:0] lbl_out,
    output logic [1:0]         uf_op,
    output logic [LABEL_W-1:0] uf_node1,
    output logic [LABEL_W-1:0] uf_node2,
    input  logic               uf_idle,
    input  logic               uf_done,
    output logic               lbl_ovf
);
`ifdef CCL_CONN8_EN
    localparam int unsigned NN = 4;
`else
    localparam int unsigned NN = 2;
`endif
    localparam int unsigned      COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned      ROW_W    = 16;
    localparam logic [LABEL_W:0] MAX_LBL  = {1'b0, {LABEL_W{1'b1}}};
    localparam logic [LABEL_W:0] ONE_LBL  = 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

    typedef enum logic [1:0] {S_RUN, S_UREQ, S_UWAIT} state_t;
    state_t state, state_n;

    logic [LABEL_W-1:0] line_buf [IMG_W];
    logic [LABEL_W-1:0] nb       [NN];
    logic [LABEL_W-1:0] nb_reg   [NN];
    logic [COL_W-1:0]   col, col_e;
    logic [ROW_W-1:0]   row, row_e;
    logic [LABEL_W:0]   next_label, nl_e;
    logic [LABEL_W-1:0] left_reg, up_raw, min_nb, lbl_new, asg_reg, other;
    logic [NN-1:0]      pend, pend_new, sel;
    logic               accept, any_nb, new_lbl, ovf_e, ovf_set, dup;
`ifdef CCL_CONN8_EN
    logic [LABEL_W-1:0] ul_reg;
    logic [COL_W-1:0]   ur_idx;
`endif

    assign pix_ready = (state == S_RUN);
    assign accept    = pix_valid && (state == S_RUN);

    always_comb begin
        col_e   = pix_sof ? '0 : col;
        row_e   = pix_sof ? '0 : row;
        nl_e    = pix_sof ? ONE_LBL : next_label;
        ovf_e   = pix_sof ? 1'b0 : lbl_ovf;
        up_raw  = line_buf[col_e];
        nb[0]   = (col_e == '0) ? '0 : left_reg;
        nb[1]   = (row_e == '0) ? '0 : up_raw;
`ifdef CCL_CONN8_EN
        // up-left comes from the previous pixel's pre-write buffer read
        ur_idx  = (col_e == LAST_COL) ? '0 : col_e + 1'b1;
        nb[2]   = (row_e == '0 || col_e == '0) ? '0 : ul_reg;
        nb[3]   = (row_e == '0 || col_e == LAST_COL) ? '0 : line_buf[ur_idx];
`endif
        min_nb  = '1;
        any_nb  = 1'b0;
        for (int unsigned i = 0; i < NN; i++) begin
            if (nb[i] != '0 && nb[i] <= min_nb) begin
                min_nb = nb[i];
                any_nb = 1'b1;
            end
        end
        lbl_new  = '0;
        new_lbl  = 1'b0;
        ovf_set  = 1'b0;
        pend_new = '0;
        dup      = 1'b0;
        if (pix_bin) begin
            if (any_nb) begin
                lbl_new = min_nb;
                for (int unsigned i = 0; i < NN; i++) begin
                    dup = 1'b0;
                    for (int unsigned j = 0; j < i; j++)
                        if (nb[j] == nb[i]) dup = 1'b1;
                    if (nb[i] != '0 && nb[i] != min_nb && !dup) pend_new[i] = 1'b1;
                end
            end else if (nl_e <= MAX_LBL) begin
                lbl_new = nl_e[LABEL_W-1:0];
                new_lbl = 1'b1;
            end else begin
                ovf_set = 1'b1;
            end
        end
        // pending unions are a mask over neighbour slots; serve lowest slot first
        sel   = pend & (~pend + 1'b1);
        other = '0;
        for (int unsigned i = 0; i < NN; i++)
            if (sel[i]) other = nb_reg[i];
    end

    always_comb begin
        state_n  = state;
        uf_op    = 2'b00;
        uf_node1 = '0;
        uf_node2 = '0;
        case (state)
            S_RUN:   if (pix_valid && pend_new != '0) state_n = S_UREQ;
            S_UREQ:  if (uf_idle) begin
                         uf_op    = 2'b01;
                         uf_node1 = asg_reg;
                         uf_node2 = other;
                         state_n  = S_UWAIT;
                     end
            S_UWAIT: if (uf_done) state_n = ((pend & ~sel) != '0) ? S_UREQ : S_RUN;
            default: state_n = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_RUN;
        else          state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (accept) line_buf[col_e] <= lbl_new;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lbl_valid  <= 1'b0;
            lbl_out    <= '0;
            lbl_ovf    <= 1'b0;
            col        <= '0;
            row        <= '0;
            next_label <= ONE_LBL;
            left_reg   <= '0;
            asg_reg    <= '0;
            pend       <= '0;
            nb_reg     <= '{default: '0};
`ifdef CCL_CONN8_EN
            ul_reg     <= '0;
`endif
        end else begin
            lbl_valid <= accept;
            if (accept) begin
                lbl_out    <= lbl_new;
                col        <= (col_e == LAST_COL) ? '0 : col_e + 1'b1;
                row        <= (col_e == LAST_COL && row_e != '1) ? row_e + 1'b1 : row_e;
                next_label <= nl_e + {{LABEL_W{1'b0}}, new_lbl};
                lbl_ovf    <= ovf_e | ovf_set;
                left_reg   <= lbl_new;
                asg_reg    <= min_nb;
                pend       <= pend_new;
                nb_reg     <= nb;
`ifdef CCL_CONN8_EN
                ul_reg     <= up_raw;
`endif
            end else if (state == S_UWAIT && uf_done) begin
                pend <= pend & ~sel;
            end
        end
    end
endmodule
